// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: two-stage pipelined Rijndael ShiftRows / InvShiftRows with valid/ready.
// Nb = 4, 6 or 8 columns; the mode bit travels with each block through S1.
// Optional build macro SHIFT_ROWS_PARITY_EN adds a sticky byte-XOR invariant check on S2
// and the parity_err port.
module shift_rows_pipe #(
    parameter int unsigned NB = 4,
    parameter int unsigned W  = 32 * NB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [W-1:0] input_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] output_data,
    output logic         busy
`ifdef SHIFT_ROWS_PARITY_EN
    ,
    output logic         parity_err
`endif
);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (W != 32 * NB) begin : g_bad_w
        $error("shift_rows_pipe: W is derived from NB and must not be overridden");
    end

    // Row shift offsets; Nb = 8 uses the wider {0,1,3,4} schedule.
    function automatic int unsigned row_shift(input int unsigned r);
        case (r)
            0:       row_shift = 0;
            1:       row_shift = 1;
            2:       row_shift = (NB == 8) ? 3 : 2;
            default: row_shift = (NB == 8) ? 4 : 3;
        endcase
    endfunction

    // MSB index of byte s[r][c]; column-major, first byte in the top bits.
    function automatic int unsigned byte_msb(input int unsigned r, input int unsigned c);
        byte_msb = W - 1 - 8 * (4 * c + r);
    endfunction

    logic         v1_q, v1_d;
    logic         v2_q, v2_d;
    logic         inv1_q, inv1_d;
    logic [W-1:0] data1_q, data1_d;
    logic [W-1:0] data2_q, data2_d;
    logic [W-1:0] perm_fwd, perm_inv, perm;
    logic         adv1, adv2;

    // Both permutations are pure wiring; the captured mode bit picks one.
    always_comb begin
        perm_fwd = '0;
        perm_inv = '0;
        for (int unsigned c = 0; c < NB; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                perm_fwd[byte_msb(r, c) -: 8] =
                    data1_q[byte_msb(r, (c + row_shift(r)) % NB) -: 8];
                perm_inv[byte_msb(r, c) -: 8] =
                    data1_q[byte_msb(r, (c + NB - row_shift(r)) % NB) -: 8];
            end
        end
        perm = inv1_q ? perm_inv : perm_fwd;
    end

    // Handshake and stage next-state: S2 drains/refills first, S1 follows when S2 can take it.
    always_comb begin
        adv2    = !v2_q || out_ready;
        adv1    = !v1_q || adv2;

        v2_d    = v2_q;
        data2_d = data2_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                data2_d = perm;
            end
        end

        v1_d    = v1_q;
        data1_d = data1_q;
        inv1_d  = inv1_q;
        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                data1_d = input_data;
                inv1_d  = in_inv;
            end
        end
    end

    // Pipeline registers; reset discards any blocks in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            inv1_q  <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            inv1_q  <= inv1_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

    assign in_ready    = adv1;
    assign out_valid   = v2_q;
    assign output_data = data2_q;
    assign busy        = v1_q | v2_q;

`ifdef SHIFT_ROWS_PARITY_EN
    // A byte permutation preserves the XOR of all bytes, so S2 must match S1's XOR.
    function automatic logic [7:0] xor_bytes(input logic [W-1:0] d);
        logic [7:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < W / 8; i++) begin
            acc ^= d[8 * i +: 8];
        end
        return acc;
    endfunction

    logic [7:0] p2_q, p2_d;
    logic       err_q, err_d;
    logic       par_mismatch;

    // Parity rides alongside S2; mismatch flags in the same cycle and latches until reset.
    always_comb begin
        p2_d = p2_q;
        if (adv2 && v1_q) begin
            p2_d = xor_bytes(data1_q);
        end
        par_mismatch = v2_q && (xor_bytes(data2_q) != p2_q);
        err_d        = err_q | par_mismatch;
    end

    // Parity and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p2_q  <= '0;
            err_q <= 1'b0;
        end else begin
            p2_q  <= p2_d;
            err_q <= err_d;
        end
    end

    assign parity_err = err_q | par_mismatch;
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe: NB=4 instance for streaming/backpressure/reset,
// NB=8 instance for the wide-block offsets. Parity checks build only with SHIFT_ROWS_PARITY_EN.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [127:0] input_data, output_data;
    logic         in8_valid, in8_ready, in8_inv, out8_valid, busy8;
    logic [255:0] in8_data, out8_data;
`ifdef SHIFT_ROWS_PARITY_EN
    logic         parity_err, parity_err8;
`endif

    shift_rows_pipe #(.NB(4)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inv      (in_inv),
        .input_data  (input_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .output_data (output_data),
        .busy        (busy)
`ifdef SHIFT_ROWS_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    shift_rows_pipe #(.NB(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in8_valid),
        .in_ready    (in8_ready),
        .in_inv      (in8_inv),
        .input_data  (in8_data),
        .out_valid   (out8_valid),
        .out_ready   (1'b1),
        .output_data (out8_data),
        .busy        (busy8)
`ifdef SHIFT_ROWS_PARITY_EN
        ,
        .parity_err  (parity_err8)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Independent reference: gather bytes, scatter by row offset.
    function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] d,
                                              input logic inv);
        logic [7:0]   b[32];
        logic [7:0]   o[32];
        int           sh[4];
        logic [255:0] r;
        sh[0] = 0;
        sh[1] = 1;
        sh[2] = (nb == 8) ? 3 : 2;
        sh[3] = (nb == 8) ? 4 : 3;
        for (int i = 0; i < 32; i++) begin
            b[i] = '0;
            o[i] = '0;
        end
        for (int i = 0; i < 4 * nb; i++) b[i] = d[32 * nb - 1 - 8 * i -: 8];
        for (int c = 0; c < nb; c++) begin
            for (int k = 0; k < 4; k++) begin
                int s;
                s = (c + sh[k]) % nb;
                if (!inv) o[4 * c + k] = b[4 * s + k];
                else      o[4 * s + k] = b[4 * c + k];
            end
        end
        r = '0;
        for (int i = 0; i < 4 * nb; i++) r[32 * nb - 1 - 8 * i -: 8] = o[i];
        return r;
    endfunction

    logic [127:0] exp_q[$];
    int           acc_cyc_q[$];
    int           out_cyc_q[$];
    int           cyc = 0;
    int           n_out = 0;
    int           n_acc = 0;
    logic         acc_flag = 1'b0;
    logic         rnd_bp = 1'b0;
    logic         sb_en = 1'b1;
    logic [127:0] last_out = '0;
    logic [255:0] got8 = '0;
    logic         got8_v = 1'b0;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic flush();
        exp_q.delete();
        acc_cyc_q.delete();
        out_cyc_q.delete();
        n_out = 0;
        n_acc = 0;
    endtask

    // One clock: sample handshakes at the falling edge, drive changes #1 after the rising edge.
    task automatic tick();
        logic [255:0] tmp;
        logic [127:0] exp_w;
        if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
        acc_flag = 1'b0;
        @(negedge clk);
        if (rst) begin
            flush();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                last_out = output_data;
                out_cyc_q.push_back(cyc);
                if (sb_en) begin
                    check("sb_nonempty", 256'(exp_q.size() != 0), 256'(1));
                    if (exp_q.size() != 0) begin
                        exp_w = exp_q.pop_front();
                        check("sb_data", {128'h0, output_data}, {128'h0, exp_w});
                    end
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                acc_flag = 1'b1;
                acc_cyc_q.push_back(cyc);
                if (sb_en) begin
                    tmp = ref_perm(4, {128'h0, input_data}, in_inv);
                    exp_q.push_back(tmp[127:0]);
                end
            end
            if (out8_valid) begin
                got8   = out8_data;
                got8_v = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [127:0] d, input logic inv);
        int n;
        n          = 0;
        in_valid   = 1'b1;
        input_data = d;
        in_inv     = inv;
        do begin
            tick();
            n++;
        end while (!acc_flag && n < 200);
        check("send_accepted", 256'(acc_flag), 256'(1));
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        check("drain_empty", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic send8(input logic [255:0] d, input logic inv);
        int n;
        got8_v    = 1'b0;
        in8_valid = 1'b1;
        in8_data  = d;
        in8_inv   = inv;
        check("nb8_in_ready", 256'(in8_ready), 256'(1));
        tick();
        in8_valid = 1'b0;
        n = 0;
        while (!got8_v && n < 20) begin
            tick();
            n++;
        end
        check("nb8_out_seen", 256'(got8_v), 256'(1));
    endtask

    initial begin
        logic [127:0] hold;
        logic [255:0] seq8, fwd8;
        in_valid   = 1'b0;
        in_inv     = 1'b0;
        input_data = '0;
        out_ready  = 1'b0;
        in8_valid  = 1'b0;
        in8_inv    = 1'b0;
        in8_data   = '0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_output_data", {128'h0, output_data}, 256'(0));
        check("rst_busy8", 256'(busy8), 256'(0));
`ifdef SHIFT_ROWS_PARITY_EN
        check("rst_parity_err", 256'(parity_err), 256'(0));
`endif
        tick();
        tick();
        rst = 1'b0;
        check("post_rst_in_ready", 256'(in_ready), 256'(1));
        out_ready = 1'b1;

        // Forward known answer and two-cycle latency
        flush();
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0);
        wait_drain();
        check("fwd_kat", {128'h0, last_out}, {128'h0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
        check("fwd_outputs", 256'(out_cyc_q.size()), 256'(1));
        check("fwd_latency", 256'(out_cyc_q[0] - acc_cyc_q[0]), 256'(2));

        // Inverse known answer
        flush();
        send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1);
        wait_drain();
        check("inv_kat", {128'h0, last_out}, {128'h0, 128'hd42711aee0bf98f1b8b45de51e415230});

        // 16 back-to-back blocks, alternating mode
        flush();
        for (int i = 0; i < 16; i++) send(rnd128(), 1'(i & 1));
        wait_drain();
        check("b2b_count", 256'(out_cyc_q.size()), 256'(16));
        check("b2b_consecutive", 256'(out_cyc_q[15] - out_cyc_q[0]), 256'(15));

        // NB=8: forward on 00..1f, then inverse restores it
        for (int i = 0; i < 32; i++) seq8[255 - 8 * i -: 8] = 8'(i);
        send8(seq8, 1'b0);
        fwd8 = got8;
        check("nb8_first_col", {224'h0, fwd8[255:224]}, 256'h00050e13);
        check("nb8_fwd", fwd8, ref_perm(8, seq8, 1'b0));
        send8(fwd8, 1'b1);
        check("nb8_inv_restore", got8, seq8);
        check("nb8_idle", 256'(busy8), 256'(0));

        // Backpressure: pipeline fills after two accepts, output holds still
        flush();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        input_data = rnd128();
        in_inv     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (acc_flag) input_data = rnd128();
        end
        in_valid = 1'b0;
        check("bp_accepts", 256'(n_acc), 256'(2));
        check("bp_in_ready_low", 256'(in_ready), 256'(0));
        check("bp_out_valid", 256'(out_valid), 256'(1));
        hold = output_data;
        tick();
        tick();
        tick();
        check("bp_data_stable", {128'h0, output_data}, {128'h0, hold});
        check("bp_valid_stable", 256'(out_valid), 256'(1));

        // Random backpressure over 200 blocks
        rnd_bp = 1'b1;
        for (int i = 0; i < 200; i++) send(rnd128(), 1'($urandom_range(0, 1)));
        rnd_bp    = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("rnd_out_count", 256'(n_out), 256'(202));
`ifdef SHIFT_ROWS_PARITY_EN
        check("rnd_parity_clean", 256'(parity_err), 256'(0));
`endif

        // Reset with both stages full
        flush();
        out_ready = 1'b0;
        send(rnd128(), 1'b0);
        send(rnd128(), 1'b1);
        check("full_busy", 256'(busy), 256'(1));
        check("full_out_valid", 256'(out_valid), 256'(1));
        check("full_in_ready", 256'(in_ready), 256'(0));
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_output_data", {128'h0, output_data}, 256'(0));
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 256'(in_ready), 256'(1));
        out_ready = 1'b1;
        send(rnd128(), 1'b0);
        wait_drain();
        check("midrst_next_count", 256'(n_out), 256'(1));

`ifdef SHIFT_ROWS_PARITY_EN
        // Single-bit upset in S2 trips the sticky check immediately
        begin
            logic flip;
            flush();
            out_ready = 1'b0;
            send(rnd128(), 1'b1);
            tick();
            check("par_held", 256'(out_valid), 256'(1));
            check("par_clean", 256'(parity_err), 256'(0));
            flip = u_dut.data2_q[5];
            force u_dut.data2_q[5] = ~flip;
            #1;
            check("par_detect", 256'(parity_err), 256'(1));
            sb_en = 1'b0;
            tick();
            release u_dut.data2_q[5];
            out_ready = 1'b1;
            tick();
            tick();
            check("par_drained", 256'(out_valid), 256'(0));
            check("par_sticky", 256'(parity_err), 256'(1));
            rst = 1'b1;
            #1;
            check("par_rst_clear", 256'(parity_err), 256'(0));
            tick();
            rst   = 1'b0;
            sb_en = 1'b1;
            flush();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, pipelined Rijndael ShiftRows / InvShiftRows stage with a valid/ready handshake.
- Supports block widths Nb = 4, 6 or 8 columns, so the same unit serves AES-128/192/256 and wider Rijndael blocks.
- Mode (forward or inverse) is selected per block.
- Sits between the SubBytes and MixColumns stages in the round datapath. Two register stages give full throughput with backpressure.

Parameters:
- NB, 4, number of 32-bit columns in the state. Legal values are 4, 6 and 8; any other value is a compile-time error.
- W, 32*NB, state width in bits. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input block present
- in_ready  output  1  unit accepts a block this cycle
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the block
- input_data  input  W  state in
- out_valid  output  1  output block present
- out_ready  input  1  downstream accepts this cycle
- output_data  output  W  permuted state
- busy  output  1  either pipeline stage holds a block
- parity_err  output  1  sticky invariant-check error; exists only with the optional feature

Behaviour:
- Byte layout is column-major with the MSB byte first. State byte s[r][c] (r = 0..3, c = 0..NB-1) is bits [W-1-8*(4c+r) -: 8].
- Row shift offsets:
  - NB = 4 or 6: {0,1,2,3}
  - NB = 8: {0,1,3,4}
- Forward permutation: out[r][c] = in[r][(c + sh[r]) mod NB].
- Inverse permutation: out[r][(c + sh[r]) mod NB] = in[r][c].
- Pipeline stage S1 (input register): holds data, inv and v1.
- Stage S2 (output register): holds the permuted data and v2. The permutation is combinational between S1 and S2.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Advance rules:
  - adv2 = !v2 || out_ready
  - adv1 = !v1 || (v1 && adv2)
  - in_ready = adv1. It is combinational from out_ready; there is no combinational path from in_valid.
- Stage loading:
  - S2 loads perm(S1) when v1 && adv2.
  - v2 clears when the output transfers and nothing moves in.
  - S1 loads the input on an input transfer.
  - v1 clears when S1 moves to S2 and no new input arrives.
- Latency and throughput:
  - Accept at cycle t gives out_valid at t+2 when there is no backpressure.
  - Steady-state throughput is one block per cycle.
- Stall: while out_valid && !out_ready, output_data and out_valid stay stable. Once both stages are full, in_ready = 0.
- Simultaneous events: an output transfer, an S1→S2 move and an input transfer all in the same cycle are legal; no bubble is inserted.
- Mode independence: mixed in_inv values on back-to-back blocks are legal. Each block uses the mode captured with it.
- busy = v1 | v2.
- Reset, asynchronous, takes effect immediately, including mid-transfer:
  - v1 = v2 = 0, so out_valid = 0 and busy = 0.
  - in_ready = 1 in the first cycle after release.
  - S1 and S2 data = 0, so output_data = 0.
  - Stored inv bit = 0.
  - parity_err = 0.
  - Blocks held in the pipeline are discarded; nothing is replayed.

Optional Feature:
- Macro: SHIFT_ROWS_PARITY_EN.
- When defined:
  - The XOR of all bytes of the S1 data is registered alongside S2 as p2.
  - While v2 is set, the XOR of all bytes of output_data is compared with p2 every cycle.
  - A mismatch sets parity_err, which stays set until rst.
  - The check adds no latency and does not affect the handshake.
- When undefined: the parity_err port and all check logic are absent.

Test Plan:
- Forward, NB=4: in_inv=0, input d42711aee0bf98f1b8b45de51e415230 → output d4bf5d30e0b452aeb84111f11e2798e5 exactly 2 cycles after accept, with out_ready held at 1.
- Inverse, NB=4: in_inv=1, input d4bf5d30e0b452aeb84111f11e2798e5 → output d42711aee0bf98f1b8b45de51e415230. Then send 16 back-to-back blocks with alternating in_inv → 16 outputs in 16 consecutive cycles, each correct for its own mode.
- NB=8: forward on bytes 00..1f in order → first output column 00050e13; a following inverse on that result restores 00..1f.
- Backpressure: hold out_ready=0 while streaming → in_ready drops after 2 accepts and output_data stays stable. Then toggle out_ready randomly for 200 blocks → no loss, no duplication, order preserved.
- Reset mid-operation: assert rst with both stages full → out_valid=0, busy=0 and output_data=0 immediately. After release in_ready=1 and the next block's result is correct.
- Parity check (SHIFT_ROWS_PARITY_EN defined): force one S2 data bit flip → parity_err=1 the same cycle and it stays set until rst. Under normal traffic parity_err remains 0.
